// File: rtl/debounce_edge.sv
// Debouncer for a raw asynchronous input: two-flop synchronizer, counter-qualified
// level FSM, registered one-cycle rise/fall pulses and a wrap-around rising-edge count.
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] rise_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b10,
    ST_WAIT_LOW  = 2'b11
  } state_e;

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= CNT_ZERO;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      rcnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // A mismatching sample in a WAIT state discards the partial count entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
          lvl_d   = 1'b1;
          rise_d  = 1'b1;
          rcnt_d  = rcnt_q + CNT_W'(1);
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_WAIT_LOW: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
          lvl_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = CNT_ZERO;
        lvl_d   = 1'b0;
      end
    endcase
  end

  assign q          = lvl_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign rise_count = rcnt_q;
  assign busy       = (state_q == ST_WAIT_HIGH) || (state_q == ST_WAIT_LOW);

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: hand-derived vector table, multi-cycle reset corner cases,
// and random din runs checked against a run-length reference model.
module tb_debounce_edge;

  localparam int S = 4;

  logic       clk, rst, din;
  logic       q, rise, fall, busy;
  logic [7:0] rise_count;

  int n_checks = 0;
  int n_errors = 0;

  debounce_edge #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .q(q), .rise(rise), .fall(fall),
    .busy(busy), .rise_count(rise_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: din reaches the level logic two edges late; a level is accepted once
  // S consecutive delayed samples differ from the current level.
  logic       m_sync[$];
  int         m_run;
  logic       m_q, m_rise, m_fall;
  logic [7:0] m_cnt;

  typedef struct {
    logic       d;
    logic       eq, er, ef, eb;
    logic [7:0] ec;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = '{1'b0, 1'b0};
    m_run  = 0;
    m_q    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_cnt  = 8'd0;
  endtask

  task automatic model_edge(input logic d);
    logic smp;
    if (rst) begin
      model_reset();
    end else begin
      smp = m_sync.pop_front();
      m_sync.push_back(d);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (smp != m_q) begin
        m_run++;
        if (m_run == S) begin
          m_q    = smp;
          m_rise = smp;
          m_fall = !smp;
          if (smp) m_cnt++;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic tick(input logic d);
    din = d;
    @(posedge clk);
    model_edge(d);
    #1;
    chk("model_q", q, m_q);
    chk("model_rise", rise, m_rise);
    chk("model_fall", fall, m_fall);
    chk("model_busy", busy, m_run != 0);
    chk("model_cnt", rise_count, m_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q"}, q, 1'b0);
    chk({tag, "_rise"}, rise, 1'b0);
    chk({tag, "_fall"}, fall, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_cnt"}, rise_count, 8'd0);
  endtask

  // Raise rst between edges and require cleared outputs before the next edge.
  task automatic async_rst(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk_zero(tag);
    model_reset();
  endtask

  task automatic add(input logic d, input logic eq, input logic er, input logic ef,
                     input logic eb, input logic [7:0] ec);
    vec_t v;
    v.d = d; v.eq = eq; v.er = er; v.ef = ef; v.eb = eb; v.ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Glitch: 2 high cycles then low.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    // Clean rise: accepted at the 6th edge after din changes.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    // Clean fall.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    // 3-cycle bounce high while low.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    rst = 1'b1;
    din = 1'b0;
    model_reset();
    #1;
    chk_zero("reset_state");

    for (int i = 0; i < 3; i++) begin
      tick(~i[0]);
      chk_zero("rst_hold");
    end
    din = 1'b0;
    rst = 1'b0;
    tick(1'b0);
    tick(1'b0);

    foreach (vecs[i]) begin
      tick(vecs[i].d);
      chk("tbl_q", q, vecs[i].eq);
      chk("tbl_rise", rise, vecs[i].er);
      chk("tbl_fall", fall, vecs[i].ef);
      chk("tbl_busy", busy, vecs[i].eb);
      chk("tbl_cnt", rise_count, vecs[i].ec);
    end

    for (int r = 0; r < 80; r++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) tick(lvl);
    end

    for (int j = 0; j < 8; j++) tick(1'b1);
    chk("pre_async_q", q, 1'b1);
    async_rst("async_from_high");
    #1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) tick(1'b0);

    // Reset while qualifying a rise, then release with din still high.
    for (int j = 0; j < 3; j++) tick(1'b1);
    chk("midwait_busy", busy, 1'b1);
    async_rst("midwait");
    tick(1'b1);
    chk_zero("midwait_hold");
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick(1'b1);
      chk("rel_rise", rise, j == 6);
      chk("rel_q", q, j == 6);
      chk("rel_cnt", rise_count, (j == 6) ? 8'd1 : 8'd0);
    end

    async_rst("pre_wrap");
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      for (int j = 0; j < 6; j++) tick(1'b1);
      if (i == 255) chk("wrap_255", rise_count, 8'd255);
      if (i == 256) chk("wrap_0", rise_count, 8'd0);
      for (int j = 0; j < 6; j++) tick(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
